// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the program-counter sequencer.
// Holds the state encoding, default PC vectors and the timeout-timer width.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } seq_state_t;

    localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
    localparam logic [31:0] DEF_TRAP_PC  = 32'h0000_4180;

    // Wide enough for TIMEOUT-1 at the largest legal TIMEOUT (65535)
    localparam int TIMER_W = 16;

    function automatic logic pc_misaligned(input logic [31:0] addr);
        return |addr[1:0];
    endfunction

endpackage

// File: rtl/pc_sequencer_fetch_timer.sv
// Loadable up-counter with clear/enable and a terminal-count flag
// at TIMEOUT-1; bounds how long a fetch may wait for imem_ack.
module fetch_timer
    import pc_seq_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               en,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_val,
    output logic               tc
);

    localparam logic [TIMER_W-1:0] TC_VAL = TIMER_W'(TIMEOUT - 1);

    logic [TIMER_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == TC_VAL);

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle fetch/execute sequencer owning the core's program counter.
// Optional misaligned-target trap redirect: define PC_SEQ_TRAP_EN.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter logic [31:0] TRAP_PC  = DEF_TRAP_PC,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ir,
    output logic        ir_valid,
    output logic [31:0] pc,
    input  logic [31:0] next_pc,
    input  logic        exec_done,
    input  logic        halt,
    output logic        running,
    output logic        halted,
    output logic        bus_err,
    output logic        trap,
    output logic [31:0] retired
);

    seq_state_t  state_q;
    seq_state_t  state_d;
    logic [31:0] pc_q;
    logic [31:0] ir_q;
    logic        ir_valid_q;
    logic        bus_err_q;
    logic        trap_q;
    logic [31:0] retired_q;

    logic        fetch_ok;
    logic        fetch_to;
    logic        exec_fire;
    logic        tmr_clr;
    logic        tmr_en;
    logic        tmr_tc;
    logic [31:0] pc_load;
    logic        trap_set;

    // Timer runs only while waiting in FETCH; an ack restarts it
    assign tmr_clr = (state_q != FETCH) || imem_ack;
    assign tmr_en  = (state_q == FETCH);

    fetch_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_fetch_timer (
        .clk      (clk),
        .rst      (rst),
        .clr      (tmr_clr),
        .en       (tmr_en),
        .load     (1'b0),
        .load_val ('0),
        .tc       (tmr_tc)
    );

`ifdef PC_SEQ_TRAP_EN
    assign trap_set = pc_misaligned(next_pc);
    assign pc_load  = trap_set ? TRAP_PC : next_pc;
`else
    logic unused_trap_cfg;
    assign unused_trap_cfg = ^{TRAP_PC, next_pc[1:0]};
    assign trap_set = 1'b0;
    assign pc_load  = {next_pc[31:2], 2'b00};
`endif

    always_comb begin
        state_d   = state_q;
        fetch_ok  = 1'b0;
        fetch_to  = 1'b0;
        exec_fire = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                // A late ack beats a coincident timeout
                if (imem_ack) begin
                    fetch_ok = 1'b1;
                    state_d  = EXEC;
                end else if (tmr_tc) begin
                    fetch_to = 1'b1;
                    state_d  = HALT;
                end
            end
            EXEC: begin
                if (exec_done) begin
                    exec_fire = 1'b1;
                    state_d   = halt ? HALT : FETCH;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            ir_q       <= '0;
            ir_valid_q <= 1'b0;
            bus_err_q  <= 1'b0;
            trap_q     <= 1'b0;
            retired_q  <= '0;
        end else begin
            state_q    <= state_d;
            ir_valid_q <= fetch_ok;
            trap_q     <= exec_fire && trap_set;
            if (fetch_ok) begin
                ir_q <= imem_rdata;
            end
            if (fetch_to) begin
                bus_err_q <= 1'b1;
            end
            if (exec_fire) begin
                pc_q      <= pc_load;
                retired_q <= retired_q + 32'd1;
            end
        end
    end

    assign imem_req  = (state_q == FETCH);
    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign ir        = ir_q;
    assign ir_valid  = ir_valid_q;
    assign running   = (state_q == FETCH) || (state_q == EXEC);
    assign halted    = (state_q == HALT);
    assign bus_err   = bus_err_q;
    assign trap      = trap_q;
    assign retired   = retired_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: fetch handshake, wait states,
// halt, fetch timeout, PC alignment/trap and reset during ack.
module tb_pc_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] ir;
    logic        ir_valid;
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic        exec_done;
    logic        halt;
    logic        running;
    logic        halted;
    logic        bus_err;
    logic        trap;
    logic [31:0] retired;

    int n_chk;
    int n_fail;
    int req_cnt;

    pc_sequencer #(
        .RESET_PC (32'h0000_3000),
        .TRAP_PC  (32'h0000_4180),
        .TIMEOUT  (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .ir         (ir),
        .ir_valid   (ir_valid),
        .pc         (pc),
        .next_pc    (next_pc),
        .exec_done  (exec_done),
        .halt       (halt),
        .running    (running),
        .halted     (halted),
        .bus_err    (bus_err),
        .trap       (trap),
        .retired    (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        n_chk      = 0;
        n_fail     = 0;
        rst        = 1'b1;
        start      = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = '0;
        next_pc    = '0;
        exec_done  = 1'b0;
        halt       = 1'b0;
        tick();
        tick();

        check("rst_pc", pc, 32'h3000);
        check("rst_addr", imem_addr, 32'h3000);
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_ir", ir, 32'd0);
        check("rst_irv", {31'd0, ir_valid}, 32'd0);
        check("rst_run", {31'd0, running}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_buserr", {31'd0, bus_err}, 32'd0);
        check("rst_trap", {31'd0, trap}, 32'd0);
        check("rst_retired", retired, 32'd0);

        // zero-wait fetch, exec_done in the ir_valid cycle
        rst   = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("f1_req", {31'd0, imem_req}, 32'd1);
        check("f1_addr", imem_addr, 32'h3000);
        check("f1_run", {31'd0, running}, 32'd1);
        imem_ack   = 1'b1;
        imem_rdata = 32'h2402_0001;
        tick();
        imem_ack = 1'b0;
        check("e1_req", {31'd0, imem_req}, 32'd0);
        check("e1_irv", {31'd0, ir_valid}, 32'd1);
        check("e1_ir", ir, 32'h2402_0001);
        exec_done = 1'b1;
        next_pc   = 32'h3004;
        tick();
        exec_done = 1'b0;
        check("f2_req", {31'd0, imem_req}, 32'd1);
        check("f2_addr", imem_addr, 32'h3004);
        check("f2_irv", {31'd0, ir_valid}, 32'd0);
        check("f2_retired", retired, 32'd1);

        // three wait states: four request cycles, stable address
        for (int i = 0; i < 3; i++) begin
            check("ws_req", {31'd0, imem_req}, 32'd1);
            check("ws_addr", imem_addr, 32'h3004);
            check("ws_irv", {31'd0, ir_valid}, 32'd0);
            tick();
        end
        check("ws4_req", {31'd0, imem_req}, 32'd1);
        check("ws4_addr", imem_addr, 32'h3004);
        imem_ack   = 1'b1;
        imem_rdata = 32'h00A0_0093;
        tick();
        imem_ack = 1'b0;
        check("ws_ack_irv", {31'd0, ir_valid}, 32'd1);
        check("ws_ack_ir", ir, 32'h00A0_0093);
        check("ws_ack_req", {31'd0, imem_req}, 32'd0);
        tick();
        check("ws_pulse_end", {31'd0, ir_valid}, 32'd0);
        check("ws_exec_run", {31'd0, running}, 32'd1);
        check("ws_exec_pc", pc, 32'h3004);

        // halt together with exec_done
        exec_done = 1'b1;
        halt      = 1'b1;
        next_pc   = 32'h3008;
        tick();
        exec_done = 1'b0;
        halt      = 1'b0;
        check("h_pc", pc, 32'h3008);
        check("h_halted", {31'd0, halted}, 32'd1);
        check("h_req", {31'd0, imem_req}, 32'd0);
        check("h_run", {31'd0, running}, 32'd0);
        check("h_retired", retired, 32'd2);
        start = 1'b1;
        tick();
        tick();
        start = 1'b0;
        check("h_start_ign", {31'd0, halted}, 32'd1);
        check("h_start_req", {31'd0, imem_req}, 32'd0);

        // no ack: timeout after exactly 16 FETCH cycles
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("to_rst_halted", {31'd0, halted}, 32'd0);
        start = 1'b1;
        tick();
        start   = 1'b0;
        req_cnt = 0;
        while (imem_req && req_cnt < 40) begin
            req_cnt++;
            tick();
        end
        check("to_cycles", req_cnt, 32'd16);
        check("to_buserr", {31'd0, bus_err}, 32'd1);
        check("to_halted", {31'd0, halted}, 32'd1);

        // ack on the 16th cycle wins over the timeout
        rst = 1'b1;
        tick();
        rst   = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        check("to16_req", {31'd0, imem_req}, 32'd1);
        imem_ack   = 1'b1;
        imem_rdata = 32'h1234_5678;
        tick();
        imem_ack = 1'b0;
        check("to16_run", {31'd0, running}, 32'd1);
        check("to16_halted", {31'd0, halted}, 32'd0);
        check("to16_buserr", {31'd0, bus_err}, 32'd0);
        check("to16_ir", ir, 32'h1234_5678);

        // misaligned next_pc
        exec_done = 1'b1;
        next_pc   = 32'h3006;
        tick();
        exec_done = 1'b0;
`ifdef PC_SEQ_TRAP_EN
        check("mis_pc", pc, 32'h4180);
        check("mis_trap", {31'd0, trap}, 32'd1);
`else
        check("mis_pc", pc, 32'h3004);
        check("mis_trap", {31'd0, trap}, 32'd0);
`endif
        check("mis_req", {31'd0, imem_req}, 32'd1);
        check("mis_retired", retired, 32'd1);
        tick();
        check("mis_trap_end", {31'd0, trap}, 32'd0);

        // reset coincident with ack
        imem_ack   = 1'b1;
        imem_rdata = 32'hFFFF_FFFF;
        rst        = 1'b1;
        tick();
        rst      = 1'b0;
        imem_ack = 1'b0;
        check("ra_pc", pc, 32'h3000);
        check("ra_req", {31'd0, imem_req}, 32'd0);
        check("ra_run", {31'd0, running}, 32'd0);
        check("ra_ir", ir, 32'd0);
        check("ra_irv", {31'd0, ir_valid}, 32'd0);
        check("ra_retired", retired, 32'd0);
        tick();
        check("ra_idle", {31'd0, running}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Multi-cycle instruction sequencer that owns the program counter for the CPU core. It fetches each instruction from instruction memory over a req/ack handshake, presents it to the execute datapath, and loads the next-PC value from the branch/jump next-PC logic when execution completes. It also detects halt requests and memory time-outs and counts retired instructions.

## Interface
Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset
- TRAP_PC, 32'h0000_4180, redirect target for a misaligned next PC (used only when PC_SEQ_TRAP_EN is defined)
- TIMEOUT, 16, maximum number of FETCH cycles without imem_ack; legal range 2..65535

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  leaves IDLE and begins fetching at pc
- imem_req  out  1  fetch request to instruction memory
- imem_addr  out  32  fetch address; always equals pc
- imem_ack  in  1  memory has imem_rdata valid this cycle
- imem_rdata  in  32  instruction word
- ir  out  32  latched instruction
- ir_valid  out  1  one-cycle pulse when ir is newly loaded
- pc  out  32  current PC, fed to the next-PC logic
- next_pc  in  32  next-PC value from the next-PC logic
- exec_done  in  1  datapath finished; next_pc is valid
- halt  in  1  decoder halt request, qualified by exec_done
- running  out  1  state is FETCH or EXEC
- halted  out  1  state is HALT
- bus_err  out  1  sticky flag: fetch timed out
- trap  out  1  one-cycle pulse on a misaligned redirect
- retired  out  32  count of completed instructions; wraps modulo 2^32

## Operation
- States: IDLE, FETCH, EXEC, HALT. State is registered, and imem_req, running and halted decode directly from it.
- IDLE → FETCH when start=1.
- FETCH
  - imem_req=1; imem_addr holds pc stable.
  - On imem_ack=1: ir←imem_rdata, ir_valid←1 for the next cycle only, state → EXEC, timer cleared.
  - Without imem_ack: timer increments. When timer reaches TIMEOUT-1 with no ack, state → HALT and bus_err←1.
  - If ack and timeout coincide, ack wins.
- EXEC
  - Wait for exec_done.
  - On exec_done: pc←processed next_pc, retired←retired+1.
  - If halt=1 in the same cycle, state → HALT; otherwise state → FETCH.
- HALT is absorbing until rst; start is ignored there.
- Ignored inputs:
  - exec_done and halt outside EXEC
  - imem_ack outside FETCH
  - halt without exec_done
- Next-PC processing depends on PC_SEQ_TRAP_EN (see Configuration).

## Timing
- Reset values:
  - state IDLE; pc = imem_addr = RESET_PC
  - ir=0; ir_valid=0; imem_req=0
  - running=0; halted=0; bus_err=0; trap=0; retired=0; timer=0
- rst mid-operation: abandons any fetch in flight, drops imem_req the next cycle, and ignores a coincident ack.
- Zero-wait memory: imem_ack arrives in the first FETCH cycle.
  - exec_done may be high in the same cycle as the ir_valid pulse.
  - Minimum cost is 2 cycles per instruction.
- pc changes only on the EXEC exec_done edge, so the next-PC logic sees a stable pc for the whole instruction.
- A timeout is declared after exactly TIMEOUT unacknowledged FETCH cycles.

## Configuration
- PC_SEQ_TRAP_EN defined:
  - next_pc[1:0]≠0 loads pc←TRAP_PC and pulses trap for one cycle.
  - The instruction still counts as retired, and sequencing continues with FETCH.
- PC_SEQ_TRAP_EN undefined:
  - pc←{next_pc[31:2],2'b00}.
  - trap is tied 0 and the port stays present.

## Structure
- Shared package pc_seq_pkg:
  - state enum (IDLE, FETCH, EXEC, HALT)
  - default RESET_PC and TRAP_PC constants
  - the width of the timer
- Sub-module fetch_timer: a loadable up-counter with clear/enable and a terminal-count flag at TIMEOUT-1, instantiated once for the FETCH timeout.

## Test plan
- Reset then start, zero-wait memory returning 0x2402_0001, exec_done in the ir_valid cycle, next_pc=0x3004 → imem_addr 0x3000 then 0x3004, with 2 cycles between requests; retired=1.
- Memory with 3 wait states → imem_req held high for 4 cycles with imem_addr stable; ir_valid is a single pulse after the ack.
- exec_done with halt=1 and next_pc=0x3008 → state HALT, pc=0x3008, halted=1, imem_req=0; later start pulses ignored.
- No ack with TIMEOUT=16 → HALT and bus_err=1 after exactly 16 FETCH cycles. Repeat with the ack on the 16th cycle → EXEC, bus_err=0.
- next_pc=0x3006: with PC_SEQ_TRAP_EN → pc=0x4180 and trap pulses; without it → pc=0x3004 and trap=0.
- rst asserted in the same cycle as imem_ack → next cycle pc=0x3000, IDLE, ir=0, retired=0.
